// File: rtl/pipeline_pkg.sv
// Shared types for the vertex-to-triangle stage: vertex, bounding box,
// triangle records and the vertex collection state encoding.
package pipeline_pkg;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic        [15:0] exc;
  } vertex_t;

  typedef struct packed {
    logic signed [15:0] xmin;
    logic signed [15:0] xmax;
    logic signed [15:0] ymin;
    logic signed [15:0] ymax;
  } bbox_t;

  typedef struct packed {
    vertex_t v0;
    vertex_t v1;
    vertex_t v2;
    bbox_t   bbox;
  } triangle_t;

  typedef enum logic [1:0] {
    S_V0 = 2'd0,
    S_V1 = 2'd1,
    S_V2 = 2'd2
  } asm_state_e;

endpackage

// File: rtl/tri_fifo.sv
// Synchronous triangle FIFO with registered full/empty flags; the head entry
// is presented combinationally.
module tri_fifo
  import pipeline_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  triangle_t pushData,
  input  logic      pop,
  output triangle_t headData,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  triangle_t       mem [FIFO_DEPTH];
  logic [AW-1:0]   wrPtr;
  logic [AW-1:0]   rdPtr;
  logic [AW:0]     count;
  logic [AW:0]     countNext;
  logic            doPush;
  logic            doPop;

  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  always_comb begin
    countNext = count;
    if (doPush && !doPop) countNext = count + (AW+1)'(1);
    else if (doPop && !doPush) countNext = count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      count <= countNext;
      full  <= (countNext == DEPTH_C);
      empty <= (countNext == '0);
    end
  end

  // Storage carries data only; validity is tracked by the pointers and flags.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  assign headData = mem[rdPtr];

endmodule

// File: rtl/triangle_assembler.sv
// Groups accepted vertices into triangles, culls invalid/degenerate/off-screen
// ones, forces CCW winding, clamps the bounding box and queues the result.
module triangle_assembler
  import pipeline_pkg::*;
#(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  input  logic [15:0] in_exc,
  input  logic        in_last,
  output logic        tri_valid,
  input  logic        tri_ready,
  output logic [15:0] tri_x0,
  output logic [15:0] tri_y0,
  output logic [15:0] tri_x1,
  output logic [15:0] tri_y1,
  output logic [15:0] tri_x2,
  output logic [15:0] tri_y2,
  output logic [15:0] bb_xmin,
  output logic [15:0] bb_xmax,
  output logic [15:0] bb_ymin,
  output logic [15:0] bb_ymax,
  output logic [15:0] cull_count,
  output logic        partial_drop
);

  localparam logic signed [15:0] X_HI = 16'(SCREEN_W - 1);
  localparam logic signed [15:0] Y_HI = 16'(SCREEN_H - 1);

  function automatic logic signed [16:0] diff17(input logic signed [15:0] a,
                                                input logic signed [15:0] b);
    logic signed [16:0] ae;
    logic signed [16:0] be;
    ae = {a[15], a};
    be = {b[15], b};
    return ae - be;
  endfunction

  function automatic logic signed [15:0] min3(input logic signed [15:0] a,
                                              input logic signed [15:0] b,
                                              input logic signed [15:0] c);
    logic signed [15:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [15:0] max3(input logic signed [15:0] a,
                                              input logic signed [15:0] b,
                                              input logic signed [15:0] c);
    logic signed [15:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic signed [15:0] clampCoord(input logic signed [15:0] v,
                                                    input logic signed [15:0] hi);
    if (v < 16'sd0) return 16'sd0;
    if (v > hi)     return hi;
    return v;
  endfunction

  asm_state_e state;
  asm_state_e stateNext;
  logic       accept;
  logic       fifoFull;
  logic       fifoEmpty;
  vertex_t    curVtx;
  vertex_t    v0Reg;
  vertex_t    v1Reg;

  assign accept = in_valid && in_ready;

  always_comb begin
    curVtx.x   = in_x;
    curVtx.y   = in_y;
    curVtx.exc = in_exc;
  end

  // Collection FSM: state register / next state / outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_V0;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (accept) begin
      if (in_last && state != S_V2) begin
        stateNext = S_V0;
      end else begin
        case (state)
          S_V0:    stateNext = S_V1;
          S_V1:    stateNext = S_V2;
          default: stateNext = S_V0;
        endcase
      end
    end
  end

  always_comb begin
    in_ready = (state != S_V2) || !fifoFull;
  end

  always_ff @(posedge clk) begin
    if (accept && state == S_V0) v0Reg <= curVtx;
    if (accept && state == S_V1) v1Reg <= curVtx;
  end

  // Triangle evaluation against the incoming third vertex.
  logic signed [15:0] x0, y0, x1, y1, x2, y2;
  logic signed [33:0] dx1, dy1, dx2, dy2;
  logic signed [33:0] prodA, prodB;
  logic signed [34:0] area;
  logic signed [15:0] rawXmin, rawXmax, rawYmin, rawYmax;
  logic               excBad, offScreen, cullTri, completing;
  triangle_t          newTri;

  always_comb begin
    x0 = v0Reg.x;
    y0 = v0Reg.y;
    x1 = v1Reg.x;
    y1 = v1Reg.y;
    x2 = curVtx.x;
    y2 = curVtx.y;
    dx1 = 34'(diff17(x1, x0));
    dy1 = 34'(diff17(y1, y0));
    dx2 = 34'(diff17(x2, x0));
    dy2 = 34'(diff17(y2, y0));
    prodA = dx1 * dy2;
    prodB = dx2 * dy1;
    area  = 35'(prodA) - 35'(prodB);

    rawXmin = min3(x0, x1, x2);
    rawXmax = max3(x0, x1, x2);
    rawYmin = min3(y0, y1, y2);
    rawYmax = max3(y0, y1, y2);

    excBad    = (v0Reg.exc != '0) || (v1Reg.exc != '0) || (curVtx.exc != '0);
    offScreen = (rawXmax < 16'sd0) || (rawXmin > X_HI) ||
                (rawYmax < 16'sd0) || (rawYmin > Y_HI);
    cullTri   = excBad || (area == '0) || offScreen;

    newTri.v0 = v0Reg;
    newTri.v1 = area[34] ? curVtx : v1Reg;
    newTri.v2 = area[34] ? v1Reg : curVtx;
    newTri.bbox.xmin = clampCoord(rawXmin, X_HI);
    newTri.bbox.xmax = clampCoord(rawXmax, X_HI);
    newTri.bbox.ymin = clampCoord(rawYmin, Y_HI);
    newTri.bbox.ymax = clampCoord(rawYmax, Y_HI);
  end

  assign completing = accept && (state == S_V2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cull_count   <= '0;
      partial_drop <= 1'b0;
    end else begin
      partial_drop <= accept && in_last && (state != S_V2);
      if (completing && cullTri && cull_count != 16'hFFFF)
        cull_count <= cull_count + 16'd1;
    end
  end

  // Output FIFO; head is forced to zero while empty so reset shows zeros.
  triangle_t fifoHead;
  triangle_t headTri;

  tri_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (completing && !cullTri),
    .pushData(newTri),
    .pop     (tri_valid && tri_ready),
    .headData(fifoHead),
    .full    (fifoFull),
    .empty   (fifoEmpty)
  );

  always_comb begin
    headTri   = fifoEmpty ? '0 : fifoHead;
    tri_valid = !fifoEmpty;
    tri_x0    = headTri.v0.x;
    tri_y0    = headTri.v0.y;
    tri_x1    = headTri.v1.x;
    tri_y1    = headTri.v1.y;
    tri_x2    = headTri.v2.x;
    tri_y2    = headTri.v2.y;
    bb_xmin   = headTri.bbox.xmin;
    bb_xmax   = headTri.bbox.xmax;
    bb_ymin   = headTri.bbox.ymin;
    bb_ymax   = headTri.bbox.ymax;
  end

endmodule

// File: tb/tb_triangle_assembler.sv
// Directed bench for triangle_assembler with a queue-based reference model
// checked every cycle plus hand-computed literal expectations.
module tb_triangle_assembler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = '0;
  logic [15:0] in_y = '0;
  logic [15:0] in_exc = '0;
  logic        in_last = 1'b0;
  logic        tri_valid;
  logic        tri_ready = 1'b0;
  logic [15:0] tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2;
  logic [15:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
  logic [15:0] cull_count;
  logic        partial_drop;

  always #5 clk = ~clk;

  triangle_assembler #(
    .SCREEN_W(640),
    .SCREEN_H(480),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_exc(in_exc), .in_last(in_last),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_x0(tri_x0), .tri_y0(tri_y0), .tri_x1(tri_x1), .tri_y1(tri_y1),
    .tri_x2(tri_x2), .tri_y2(tri_y2),
    .bb_xmin(bb_xmin), .bb_xmax(bb_xmax), .bb_ymin(bb_ymin), .bb_ymax(bb_ymax),
    .cull_count(cull_count), .partial_drop(partial_drop)
  );

  int checks = 0;
  int errors = 0;
  bit modelOn = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: triangles computed from the rules with plain integers.
  typedef struct {
    int x0, y0, x1, y1, x2, y2;
    int bxmin, bxmax, bymin, bymax;
  } mtri_t;

  localparam int SW = 640;
  localparam int SH = 480;
  localparam int DEPTH = 4;

  mtri_t q[$];
  int    vc = 0;
  int    hx[2], hy[2], he[2];
  int    mCull = 0;
  bit    mPd = 0;

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
  function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction

  function automatic bit modelReady();
    return !(vc == 2 && q.size() == DEPTH);
  endfunction

  task automatic completeTri(input int x2, input int y2, input int e2);
    longint a;
    int xmn, xmx, ymn, ymx;
    mtri_t t;
    a = longint'(hx[1] - hx[0]) * longint'(y2 - hy[0]) -
        longint'(x2 - hx[0]) * longint'(hy[1] - hy[0]);
    xmn = imin(imin(hx[0], hx[1]), x2);
    xmx = imax(imax(hx[0], hx[1]), x2);
    ymn = imin(imin(hy[0], hy[1]), y2);
    ymx = imax(imax(hy[0], hy[1]), y2);
    if (he[0] != 0 || he[1] != 0 || e2 != 0 || a == 0 ||
        xmx < 0 || xmn > SW - 1 || ymx < 0 || ymn > SH - 1) begin
      if (mCull < 65535) mCull++;
    end else begin
      t.x0 = hx[0]; t.y0 = hy[0];
      if (a > 0) begin
        t.x1 = hx[1]; t.y1 = hy[1]; t.x2 = x2; t.y2 = y2;
      end else begin
        t.x1 = x2; t.y1 = y2; t.x2 = hx[1]; t.y2 = hy[1];
      end
      t.bxmin = clampi(xmn, SW - 1); t.bxmax = clampi(xmx, SW - 1);
      t.bymin = clampi(ymn, SH - 1); t.bymax = clampi(ymx, SH - 1);
      q.push_back(t);
    end
  endtask

  always @(negedge clk) begin
    bit acc, pop;
    int vx, vy, ve;
    if (modelOn) begin
      chk("in_ready", in_ready, modelReady());
      chk("tri_valid", tri_valid, q.size() > 0);
      chk("cull_count", cull_count, mCull);
      chk("partial_drop", partial_drop, mPd);
      if (q.size() > 0) begin
        chk("tri_x0", tri_x0, q[0].x0); chk("tri_y0", tri_y0, q[0].y0);
        chk("tri_x1", tri_x1, q[0].x1); chk("tri_y1", tri_y1, q[0].y1);
        chk("tri_x2", tri_x2, q[0].x2); chk("tri_y2", tri_y2, q[0].y2);
        chk("bb_xmin", bb_xmin, q[0].bxmin); chk("bb_xmax", bb_xmax, q[0].bxmax);
        chk("bb_ymin", bb_ymin, q[0].bymin); chk("bb_ymax", bb_ymax, q[0].bymax);
      end
    end
    // Advance the model to the state after the coming rising edge.
    if (!rst_n) begin
      q.delete(); vc = 0; mCull = 0; mPd = 0;
    end else begin
      acc = in_valid && modelReady();
      pop = (q.size() > 0) && tri_ready;
      mPd = 0;
      if (pop) void'(q.pop_front());
      if (acc) begin
        vx = int'($signed(in_x)); vy = int'($signed(in_y)); ve = int'(in_exc);
        if (vc < 2 && in_last) begin
          vc = 0; mPd = 1;
        end else if (vc < 2) begin
          hx[vc] = vx; hy[vc] = vy; he[vc] = ve; vc++;
        end else begin
          completeTri(vx, vy, ve);
          vc = 0;
        end
      end
    end
  end

  task automatic sendVtx(input int x, input int y, input int e, input bit last);
    bit acc;
    int n;
    acc = 0; n = 0;
    in_valid = 1'b1; in_x = x[15:0]; in_y = y[15:0]; in_exc = e[15:0]; in_last = last;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: vertex (%0d,%0d) not accepted within 200 cycles", x, y);
    end
  endtask

  task automatic sendTri(input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy, input int be);
    sendVtx(ax, ay, 0, 1'b0);
    sendVtx(bx, by, be, 1'b0);
    sendVtx(cx, cy, 0, 1'b1);
  endtask

  task automatic nextCycle();
    @(posedge clk); #1;
  endtask

  initial begin
    tri_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 modelOn = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_tri_valid", tri_valid, 0);
    chk("rst_cull", cull_count, 0);
    chk("rst_pdrop", partial_drop, 0);
    chk("rst_tri_x0", tri_x0, 0);
    chk("rst_bb_xmax", bb_xmax, 0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();

    // CCW triangle passes unchanged, visible the cycle after the third vertex.
    sendTri(10, 10, 100, 10, 10, 100, 0);
    @(negedge clk);
    chk("t1_valid", tri_valid, 1);
    chk("t1_x1", tri_x1, 100); chk("t1_y1", tri_y1, 10);
    chk("t1_x2", tri_x2, 10);  chk("t1_y2", tri_y2, 100);
    chk("t1_bb_xmin", bb_xmin, 10); chk("t1_bb_xmax", bb_xmax, 100);
    chk("t1_bb_ymin", bb_ymin, 10); chk("t1_bb_ymax", bb_ymax, 100);
    nextCycle();

    // CW triangle gets V1/V2 swapped.
    sendTri(10, 10, 10, 100, 100, 10, 0);
    @(negedge clk);
    chk("t2_x1", tri_x1, 100); chk("t2_y1", tri_y1, 10);
    chk("t2_x2", tri_x2, 10);  chk("t2_y2", tri_y2, 100);
    nextCycle();

    // Degenerate, then exception on V1.
    sendTri(0, 0, 5, 5, 9, 9, 0);
    @(negedge clk);
    chk("t3_cull", cull_count, 1);
    chk("t3_novalid", tri_valid, 0);
    nextCycle();
    sendTri(0, 0, 100, 10, 10, 100, 1);
    @(negedge clk);
    chk("t3e_cull", cull_count, 2);
    nextCycle();

    // Clamped bbox, then a fully off-screen triangle.
    sendTri(-50, -20, 700, 10, 300, 600, 0);
    @(negedge clk);
    chk("t4_bb_xmin", bb_xmin, 0);   chk("t4_bb_xmax", bb_xmax, 639);
    chk("t4_bb_ymin", bb_ymin, 0);   chk("t4_bb_ymax", bb_ymax, 479);
    chk("t4_x0", tri_x0, 16'hFFCE);
    nextCycle();
    sendTri(-30, 0, -10, 5, -20, 20, 0);
    @(negedge clk);
    chk("t4o_cull", cull_count, 3);
    nextCycle();

    // Back-pressure: five triangles into a four-entry FIFO.
    tri_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          sendTri(i * 10, 0, i * 10 + 50, 0, i * 10, 50, 0);
      end
      begin
        repeat (30) @(negedge clk);
        chk("t5_in_ready_low", in_ready, 0);
        chk("t5_head_x0", tri_x0, 0);
        chk("t5_head_x1", tri_x1, 50);
        @(posedge clk); #1;
        tri_ready = 1'b1;
      end
    join
    repeat (8) nextCycle();

    // in_last on the second vertex discards the partial triangle.
    sendVtx(1, 1, 0, 1'b0);
    sendVtx(2, 2, 0, 1'b1);
    @(negedge clk);
    chk("t6_pdrop", partial_drop, 1);
    chk("t6_novalid", tri_valid, 0);
    @(negedge clk);
    chk("t6_pdrop_end", partial_drop, 0);
    nextCycle();
    sendTri(20, 20, 60, 20, 20, 60, 0);
    @(negedge clk);
    chk("t6_valid", tri_valid, 1);
    chk("t6_x1", tri_x1, 60);
    nextCycle();

    // Reset with two triangles queued.
    tri_ready = 1'b0;
    sendTri(0, 0, 30, 0, 0, 30, 0);
    sendTri(5, 5, 40, 5, 5, 40, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t7_pre_valid", tri_valid, 1);
    nextCycle();
    @(negedge clk);
    chk("t7_valid", tri_valid, 0);
    chk("t7_cull", cull_count, 0);
    chk("t7_pdrop", partial_drop, 0);
    nextCycle();
    rst_n = 1'b1;
    tri_ready = 1'b1;
    repeat (4) nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
